// File: rtl/bus_pkg.sv
// Shared arbiter types: FSM state, master id and default grant timeout.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT1  = 2'd1,
    GRANT2  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_e;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/counter.sv
// Generic up-counter with asynchronous active-high clear.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (incr) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with grant timeout and one-cycle turnaround.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin; fixed priority otherwise.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic M1_REQ,
  input  logic M2_REQ,
  input  logic B_UTIL,
  output logic M1_GRANT,
  output logic M2_GRANT,
  output logic M_SEL,
  output logic ARB_BUSY,
  output logic TIMEOUT_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e state_q, state_d;
  arb_state_e both_pick;
  logic util_seen_q, util_seen_d;
  logic cnt_clr_q, cnt_clr_d;
  logic m1_grant_q, m1_grant_d;
  logic m2_grant_q, m2_grant_d;
  logic m_sel_q, m_sel_d;
  logic busy_q, busy_d;
  logic terr_q, terr_d;
  logic [CNT_W-1:0] count;
  logic in_grant_q, in_grant_d;
  logic req_cur, incr, cnt_rst;

  assign in_grant_q = (state_q == GRANT1) || (state_q == GRANT2);
  assign in_grant_d = (state_d == GRANT1) || (state_d == GRANT2);
  assign req_cur    = (state_q == GRANT2) ? M2_REQ : M1_REQ;
  assign incr = in_grant_q && !util_seen_q && !B_UTIL
             && (count != CNT_MAX);

  // Clear is a single flop so the async clear input never glitches.
  assign cnt_rst = RSTN | cnt_clr_q;

  counter #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .rst  (cnt_rst),
    .clk  (CLK),
    .incr (incr),
    .count(count)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  master_e last_q, last_d;

  assign both_pick = (last_q == M2) ? GRANT1 : GRANT2;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && state_d == GRANT1) last_d = M1;
    if (state_q == IDLE && state_d == GRANT2) last_d = M2;
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) last_q <= M2;
    else      last_q <= last_d;
  end
`else
  assign both_pick = GRANT1;
`endif

  always_comb begin
    state_d = state_q;
    terr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (M1_REQ && M2_REQ) state_d = both_pick;
        else if (M1_REQ)      state_d = GRANT1;
        else if (M2_REQ)      state_d = GRANT2;
      end
      GRANT1, GRANT2: begin
        // A live transfer is never cut; release beats timeout.
        if (B_UTIL) begin
          state_d = state_q;
        end else if (!req_cur) begin
          state_d = RELEASE;
        end else if (!util_seen_q && count == CNT_MAX) begin
          state_d = RELEASE;
          terr_d  = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    util_seen_d = 1'b0;
    if (in_grant_d) util_seen_d = util_seen_q | (in_grant_q & B_UTIL);
    cnt_clr_d  = !in_grant_d;
    m1_grant_d = (state_d == GRANT1);
    m2_grant_d = (state_d == GRANT2);
    busy_d     = in_grant_d;
    m_sel_d    = m_sel_q;
    if (state_d == GRANT1) m_sel_d = 1'b0;
    if (state_d == GRANT2) m_sel_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q     <= IDLE;
      util_seen_q <= 1'b0;
      cnt_clr_q   <= 1'b1;
      m1_grant_q  <= 1'b0;
      m2_grant_q  <= 1'b0;
      m_sel_q     <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      util_seen_q <= util_seen_d;
      cnt_clr_q   <= cnt_clr_d;
      m1_grant_q  <= m1_grant_d;
      m2_grant_q  <= m2_grant_d;
      m_sel_q     <= m_sel_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  assign M1_GRANT    = m1_grant_q;
  assign M2_GRANT    = m2_grant_q;
  assign M_SEL       = m_sel_q;
  assign ARB_BUSY    = busy_q;
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grants, timeout, turnaround, reset.
module tb_bus_arbiter;

  logic CLK = 1'b0;
  logic RSTN = 1'b1;
  logic M1_REQ = 1'b0;
  logic M2_REQ = 1'b0;
  logic B_UTIL = 1'b0;
  logic M1_GRANT, M2_GRANT, M_SEL, ARB_BUSY, TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(
    .TIMEOUT(16),
    .CNT_W  (8)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .M1_REQ     (M1_REQ),
    .M2_REQ     (M2_REQ),
    .B_UTIL     (B_UTIL),
    .M1_GRANT   (M1_GRANT),
    .M2_GRANT   (M2_GRANT),
    .M_SEL      (M_SEL),
    .ARB_BUSY   (ARB_BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // {M1_GRANT, M2_GRANT, M_SEL, ARB_BUSY, TIMEOUT_ERR}
  function automatic logic [4:0] ev(input logic g1, input logic g2,
                                    input logic sel, input logic err);
    return {g1, g2, sel, g1 | g2, err};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {M1_GRANT, M2_GRANT, M_SEL, ARB_BUSY, TIMEOUT_ERR};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  logic w2_is_m2;

  initial begin
    #2;
    chk("reset_async", ev(0, 0, 0, 0));
    tick();
    chk("reset_held", ev(0, 0, 0, 0));
    RSTN = 1'b0;
    tick();
    chk("idle_after_reset", ev(0, 0, 0, 0));

    for (int i = 0; i < 4; i++) begin
      B_UTIL = ~B_UTIL;
      tick();
      chk("idle_butil_ignored", ev(0, 0, 0, 0));
    end
    B_UTIL = 1'b0;

    M1_REQ = 1'b1;
    tick();
    chk("m1_grant_latency", ev(1, 0, 0, 0));
    B_UTIL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("m1_transfer", ev(1, 0, 0, 0));
    end
    M1_REQ = 1'b0;
    tick();
    chk("m1_hold_while_util", ev(1, 0, 0, 0));
    B_UTIL = 1'b0;
    tick();
    chk("m1_release_no_err", ev(0, 0, 0, 0));
    tick();
    chk("m1_back_idle", ev(0, 0, 0, 0));

    M2_REQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("m2_grant_before_timeout", ev(0, 1, 1, 0));
    end
    tick();
    chk("m2_timeout_pulse", ev(0, 0, 1, 1));
    tick();
    chk("m2_idle_after_timeout", ev(0, 0, 1, 0));
    tick();
    chk("m2_regrant", ev(0, 1, 1, 0));
    M2_REQ = 1'b0;
    tick();
    chk("m2_release_no_err", ev(0, 0, 1, 0));
    tick();
    chk("m2_idle", ev(0, 0, 1, 0));

    M1_REQ = 1'b1;
    tick();
    chk("m1_regrant", ev(1, 0, 0, 0));
    B_UTIL = 1'b1;
    tick();
    chk("m1_util_seen", ev(1, 0, 0, 0));
    B_UTIL = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("m1_hold_no_timeout", ev(1, 0, 0, 0));
    end

    B_UTIL = 1'b1;
    M1_REQ = 1'b0;
    M2_REQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("m1_hold_m2_pending", ev(1, 0, 0, 0));
    end
    B_UTIL = 1'b0;
    tick();
    chk("m1_release_m2_pending", ev(0, 0, 0, 0));
    tick();
    chk("turnaround_idle", ev(0, 0, 0, 0));
    tick();
    chk("m2_after_turnaround", ev(0, 1, 1, 0));

    RSTN = 1'b1;
    #1;
    chk("reset_mid_grant2", ev(0, 0, 0, 0));
    M1_REQ = 1'b1;
    M2_REQ = 1'b1;
    tick();
    chk("reset_held_reqs", ev(0, 0, 0, 0));
    RSTN = 1'b0;
    tick();
    chk("both_after_reset_m1", ev(1, 0, 0, 0));

    B_UTIL = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rr1_m1_transfer", ev(1, 0, 0, 0));
    B_UTIL = 1'b0;
    M1_REQ = 1'b0;
    tick();
    chk("rr1_release", ev(0, 0, 0, 0));
    M1_REQ = 1'b1;
    tick();
    chk("rr1_idle", ev(0, 0, 0, 0));
    tick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
    w2_is_m2 = 1'b1;
    chk("rr2_winner", ev(0, 1, 1, 0));
`else
    w2_is_m2 = 1'b0;
    chk("fixed2_winner", ev(1, 0, 0, 0));
`endif

    B_UTIL = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    B_UTIL = 1'b0;
    if (w2_is_m2) M2_REQ = 1'b0;
    else          M1_REQ = 1'b0;
    tick();
    chk("rr2_release", ev(0, 0, w2_is_m2, 0));
    M1_REQ = 1'b1;
    M2_REQ = 1'b1;
    tick();
    chk("rr2_idle", ev(0, 0, w2_is_m2, 0));
    tick();
    chk("rr3_winner_m1", ev(1, 0, 0, 0));

    M1_REQ = 1'b0;
    M2_REQ = 1'b0;
    tick();
    chk("final_release", ev(0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles a granted master may hold GRANT without asserting B_UTIL; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the grant-timeout counter; TIMEOUT-1 SHALL fit in CNT_W bits.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RSTN  in  1  reset, asynchronous, active-high.
REQ-005 M1_REQ  in  1  bus request from master 1 (its B_REQ).
REQ-006 M2_REQ  in  1  bus request from master 2 (its B_REQ).
REQ-007 B_UTIL  in  1  bus-utilised indication, OR of both masters' B_UTIL.
REQ-008 M1_GRANT  out  1  bus grant to master 1.
REQ-009 M2_GRANT  out  1  bus grant to master 2.
REQ-010 M_SEL  out  1  bus mux select: 0 routes master 1 B_RW/B_BUS/B_UTIL to the slaves, 1 routes master 2.
REQ-011 ARB_BUSY  out  1  high whenever either grant is high.
REQ-012 TIMEOUT_ERR  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 FSM states: IDLE, GRANT1, GRANT2, RELEASE; all outputs registered.
REQ-014 IDLE: no request -> stay; only M1_REQ -> GRANT1; only M2_REQ -> GRANT2; both -> winner per REQ-024/025.
REQ-015 Latency: request sampled in IDLE at edge k -> grant high and M_SEL valid from edge k, i.e. one cycle after REQ assertion.
REQ-016 GRANTx: exactly the matching Mx_GRANT high; the other grant low; M_SEL = x-1.
REQ-017 GRANTx: util_seen flag sets on first cycle B_UTIL is high; clears on leaving GRANTx.
REQ-018 GRANTx, util_seen low: counter increments each cycle; at count == TIMEOUT-1 -> RELEASE with TIMEOUT_ERR pulsed on the same edge.
REQ-019 GRANTx, Mx_REQ low and B_UTIL low -> RELEASE with no error, regardless of util_seen.
REQ-020 GRANTx, B_UTIL high: grant held even if Mx_REQ low; the bus is never revoked mid-transfer.
REQ-021 GRANTx, Mx_REQ high and util_seen set: grant held indefinitely.
REQ-022 RELEASE: both grants low for exactly one cycle (turnaround); M_SEL holds its last value; next state IDLE unconditionally.
REQ-023 Counter resets to 0 on entry to GRANTx and saturates at TIMEOUT-1; never wraps.
REQ-024 Both requests pending in IDLE, fixed-priority mode: master 1 wins.
REQ-025 Both requests pending in IDLE, round-robin mode: the master not recorded in last_grant wins; last_grant updates on every IDLE->GRANTx transition.
REQ-026 B_UTIL high in IDLE or RELEASE: ignored; no state change, no error.

Reset
REQ-027 RSTN high: state IDLE; M1_GRANT, M2_GRANT, ARB_BUSY, TIMEOUT_ERR, M_SEL = 0; counter 0; util_seen 0; last_grant = master 2.
REQ-028 RSTN asserted mid-grant: grant drops asynchronously; after release, arbitration restarts from IDLE with no TIMEOUT_ERR.

Configuration
REQ-029 Macro BUS_ARB_ROUND_ROBIN_EN defined: REQ-025 round-robin arbitration, with last_grant register present.
REQ-030 Macro undefined: REQ-024 fixed priority; last_grant register absent; all other behaviour identical.

Structure
REQ-031 Shared package bus_pkg holds the arbiter state enum (IDLE, GRANT1, GRANT2, RELEASE), the master-id typedef (M1=0, M2=1) and the default TIMEOUT constant.
REQ-032 Timeout counting reuses the existing counter sub-module (parameter WIDTH=CNT_W; ports rst, clk, incr, count); no other sub-modules.

Verification
REQ-033 M1_REQ high at cycle 0, B_UTIL high cycles 2-10, M1_REQ low at cycle 10 -> M1_GRANT high cycles 1-10, RELEASE at 11, IDLE at 12, TIMEOUT_ERR never high.
REQ-034 TIMEOUT=16, M2_REQ held high, B_UTIL never high -> M2_GRANT high 16 cycles, TIMEOUT_ERR pulses once, then one turnaround cycle, then re-grant to M2.
REQ-035 M1_REQ and M2_REQ high together from reset, each dropping REQ after 3 B_UTIL cycles -> round-robin build: grant order M1, M2, M1; fixed build: M1, M1, M1 while M1_REQ is reasserted.
REQ-036 M1 granted, B_UTIL high, M1_REQ low -> grant held until B_UTIL falls, then RELEASE; M2_REQ pending during this time is granted only after the turnaround cycle.
REQ-037 RSTN pulsed during GRANT2 -> M2_GRANT and ARB_BUSY low immediately; M_SEL=0; next grant is to M1 when both request (round-robin build).
REQ-038 B_UTIL toggled while IDLE with no requests -> no grant, ARB_BUSY=0, TIMEOUT_ERR=0.
